muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, alongside the ALU, fed by the same SrcAE/SrcBE operands.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and holds results in architectural HI/LO registers.
- Supports MTHI/MTLO writes.
- The hazard unit stalls on Busy; MFHI/MFLO read HI/LO directly.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- Start  input  1  launch operation; sampled only when Busy=0.
- MDOp  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- SrcAE  input  WIDTH  rs operand (multiplicand / dividend).
- SrcBE  input  WIDTH  rt operand (multiplier / divisor).
- HIWrite  input  1  MTHI strobe.
- LOWrite  input  1  MTLO strobe.
- WData  input  WIDTH  MTHI/MTLO data.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse; HI/LO hold the new result.
- DivZero  output  1  sticky until next Start: last divide had SrcBE=0.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-low (rst_n); all registers update on the rising edge of clk.
  - rst_n=0 at any edge, including mid-operation, forces state IDLE and HI=LO=0, Busy=0, Done=0, DivZero=0. Any in-flight operation is discarded.
- States: IDLE, CALC, FIX.
- IDLE, Busy=0:
  - Start=1 latches MDOp and operands.
  - Signed ops (MULT, DIV) latch magnitudes plus sign bits. Unsigned ops latch raw values.
  - Counter is cleared. DivZero is cleared, or set if the op is a divide and SrcBE=0.
  - Next state is CALC, or FIX directly for divide-by-zero.
- CALC, Busy=1: exactly WIDTH cycles.
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: radix-2 restoring, one quotient bit per cycle, MSB first.
  - After the count reaches WIDTH-1, go to FIX.
- FIX, Busy=1, one cycle. Signs are applied and HI/LO are written at the end of this cycle; next state is IDLE.
  - Multiply: 2*WIDTH product, negated if signed and the operand signs differ. HI=upper WIDTH bits, LO=lower.
  - Divide: LO=quotient, negated if signed and the signs differ. HI=remainder, negated if signed and the dividend is negative.
  - Divide-by-zero: HI=SrcAE as latched, LO=all ones. No CALC phase.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- Done: asserted in the first IDLE cycle after FIX for exactly one cycle; otherwise 0.
- Latency:
  - Start sampled at edge k gives Busy=1 for cycles k+1 to k+WIDTH+1.
  - Done=1 and new HI/LO are visible in cycle k+WIDTH+2; that is Done at cycle k+34 for WIDTH=32.
  - Divide-by-zero: Busy for one cycle, Done at k+2.
- Start while Busy=1 is ignored, with no queueing. Start in the Done cycle is accepted (state is IDLE).
- MTHI/MTLO writes:
  - HIWrite/LOWrite are accepted only in IDLE with Start=0; WData lands the next cycle.
  - Both strobes in one cycle write both registers.
  - Writes while Busy, or coincident with Start, are dropped.
- HI/LO are unchanged between operations. Operands may change after the Start cycle with no effect.

Test Plan:
- MULTU, SrcAE=0xFFFFFFFF, SrcBE=0xFFFFFFFF, Start for 1 cycle -> Busy high for 33 cycles; Done at k+34; HI=0xFFFFFFFE, LO=0x00000001.
- MULT, SrcAE=-3 (0xFFFFFFFD), SrcBE=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV, SrcAE=-7, SrcBE=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU, 100/7 -> LO=14, HI=2.
- DIV, SrcAE=0x12345678, SrcBE=0 -> Busy for 1 cycle, Done at k+2, DivZero=1, HI=0x12345678, LO=0xFFFFFFFF. DIV, 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- During Busy: pulse Start with new operands and HIWrite with WData=0xDEAD -> both ignored, original result delivered. In IDLE, HIWrite with WData=0xDEAD -> HI=0xDEAD next cycle. Start and LOWrite in the same cycle -> write dropped.
- rst_n=0 for 1 cycle at CALC cycle 10 -> next cycle Busy=0, HI=LO=0, no Done pulse. A new MULTU 6x7 then gives LO=42, HI=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding architectural HI/LO, with MTHI/MTLO writes.
// Latency: WIDTH+2 cycles from Start to Done (2 cycles for divide-by-zero).
// Backpressure: Start is ignored while Busy; no queueing, the hazard unit stalls on Busy.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Start,
   input  logic [1:0]       MDOp,
   input  logic [WIDTH-1:0] SrcAE,
   input  logic [WIDTH-1:0] SrcBE,
   input  logic             HIWrite,
   input  logic             LOWrite,
   input  logic [WIDTH-1:0] WData,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Latched operation context
   logic [1:0]         op_q;
   logic               sign_a_q;
   logic               sign_b_q;
   logic [WIDTH-1:0]   b_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               done_q;
   logic               div_zero_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   // Launch-side decode
   logic               start_signed;
   logic               start_dz;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   // Iteration step and final fix-up
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_sh;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] div_next;
   logic               op_signed_q;
   logic               res_neg;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   assign Busy    = (state != IDLE);
   assign Done    = done_q;
   assign DivZero = div_zero_q;
   assign HI      = hi_q;
   assign LO      = lo_q;

   // Operand conditioning at launch: signed ops work on magnitudes, signs kept aside
   always_comb begin
      start_signed = ~MDOp[0];
      start_dz     = MDOp[1] && (SrcBE == '0);
      a_mag        = (start_signed && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
      b_mag        = (start_signed && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
   end

   // One radix-2 step: shift-add multiply (acc shifts right) or restoring divide (acc shifts left)
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
      div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff = div_sh - {1'b0, b_q};
      if (div_diff[WIDTH]) begin
         div_next = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
   end

   // Sign fix-up and HI/LO selection for the FIX cycle
   always_comb begin
      op_signed_q = ~op_q[0];
      res_neg     = op_signed_q && (sign_a_q ^ sign_b_q);
      prod        = res_neg ? -acc_q : acc_q;
      fix_hi      = prod[2*WIDTH-1:WIDTH];
      fix_lo      = prod[WIDTH-1:0];
      if (div_zero_q) begin
         // acc upper half carries the raw dividend when the divisor was zero
         fix_hi = acc_q[2*WIDTH-1:WIDTH];
         fix_lo = '1;
      end else if (op_q[1]) begin
         fix_lo = res_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
         fix_hi = (op_signed_q && sign_a_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: IDLE -> CALC (WIDTH cycles) -> FIX -> IDLE; divide-by-zero skips CALC
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (Start) begin
               state_nxt = start_dz ? FIX : CALC;
            end
         end
         CALC: begin
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_nxt = FIX;
            end
         end
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: launch latch, iteration, result write-back, MTHI/MTLO
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q       <= '0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         b_q        <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         done_q <= (state == FIX);
         case (state)
            IDLE: begin
               if (Start) begin
                  op_q       <= MDOp;
                  sign_a_q   <= start_signed & SrcAE[WIDTH-1];
                  sign_b_q   <= start_signed & SrcBE[WIDTH-1];
                  b_q        <= b_mag;
                  cnt_q      <= '0;
                  div_zero_q <= start_dz;
                  acc_q      <= start_dz ? {SrcAE, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, a_mag};
               end else begin
                  if (HIWrite) hi_q <= WData;
                  if (LOWrite) lo_q <= WData;
               end
            end
            CALC: begin
               acc_q <= op_q[1] ? div_next : mul_next;
               cnt_q <= cnt_q + 1'b1;
            end
            FIX: begin
               hi_q <= fix_hi;
               lo_q <= fix_lo;
            end
            default: ;
         endcase
      end
   end

endmodule
